// File: rtl/multiplicador.sv
// Sequential shift-and-add unsigned multiplier with init/done handshake.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand bypasses CALC and finishes straight away.
module multiplicador #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] producto,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StEnd} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] producto_q, producto_d;
    logic               done_q, done_d;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        producto_d = producto_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (init) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                a_d   = {{WIDTH{1'b0}}, mcand};
                b_d   = mplier;
                acc_d = '0;
                cnt_d = '0;
`ifdef MULT_ZERO_SKIP_EN
                if (mcand == '0 || mplier == '0) begin
                    state_d = StEnd;
                end else begin
                    state_d = StCalc;
                end
`else
                state_d = StCalc;
`endif
            end
            StCalc: begin
                // Full-width sum cannot overflow: (2^W-1)^2 < 2^(2W).
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StEnd;
                end
            end
            StEnd: begin
                producto_d = acc_q;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            producto_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            producto_q <= producto_d;
            done_q     <= done_d;
        end
    end

    assign producto = producto_q;
    assign done     = done_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_multiplicador.sv
// Directed bench for multiplicador (WIDTH=4): vector table plus hand sequences for
// back-to-back starts, operand changes mid-operation and reset mid-operation.
module tb_multiplicador;

    localparam int unsigned WIDTH = 4;
    localparam int FullLat = WIDTH + 2;
`ifdef MULT_ZERO_SKIP_EN
    localparam int ZeroLat = 2;
`else
    localparam int ZeroLat = WIDTH + 2;
`endif

    logic               clk;
    logic               rst_n;
    logic               init;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] producto;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;

    multiplicador #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (init),
        .mcand    (mcand),
        .mplier   (mplier),
        .producto (producto),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] prod;
        int                 lat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse init for one edge (edge 0), then count edges until done appears.
    task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int exp_prod, input int exp_lat);
        int n;
        mcand  = a;
        mplier = b;
        init   = 1'b1;
        cycle();
        init = 1'b0;
        check({name, " busy_after_start"}, int'(busy), 1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (done) begin
                n = i;
                break;
            end
        end
        check({name, " done_latency"}, n, exp_lat);
        check({name, " producto"}, int'(producto), exp_prod);
        check({name, " busy_at_done"}, int'(busy), 0);
        cycle();
        check({name, " done_single_cycle"}, int'(done), 0);
        check({name, " producto_held"}, int'(producto), exp_prod);
    endtask

    initial begin
        int pulses;
        int last;
        int seen;

        vecs[0] = '{a: 4'd13, b: 4'd11, prod: 8'h8F, lat: FullLat};
        vecs[1] = '{a: 4'd15, b: 4'd15, prod: 8'hE1, lat: FullLat};
        vecs[2] = '{a: 4'd1,  b: 4'd9,  prod: 8'h09, lat: FullLat};
        vecs[3] = '{a: 4'd0,  b: 4'd7,  prod: 8'h00, lat: ZeroLat};
        vecs[4] = '{a: 4'd7,  b: 4'd0,  prod: 8'h00, lat: ZeroLat};
        vecs[5] = '{a: 4'd10, b: 4'd5,  prod: 8'h32, lat: FullLat};
        vecs[6] = '{a: 4'd8,  b: 4'd1,  prod: 8'h08, lat: FullLat};

        rst_n  = 1'b0;
        init   = 1'b0;
        mcand  = '0;
        mplier = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        check("reset producto", int'(producto), 0);
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (busy || done) seen++;
        end
        check("idle no activity", seen, 0);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, int'(vecs[i].prod), vecs[i].lat);
        end

        // init held high: a new op starts right after each done pulse.
        mcand  = 4'd3;
        mplier = 4'd5;
        init   = 1'b1;
        pulses = 0;
        last   = -1;
        seen   = 0;
        for (int i = 0; i < 22; i++) begin
            cycle();
            if (done) begin
                if (pulses == 0) check("b2b first_done", i, FullLat);
                else check("b2b period", i - last, WIDTH + 3);
                check("b2b producto", int'(producto), 8'h0F);
                if (last == i - 1) seen++;
                pulses++;
                last = i;
            end
        end
        init = 1'b0;
        check("b2b pulse_count", pulses, 3);
        check("b2b no_double_done", seen, 0);
        for (int i = 0; i < 20 && busy; i++) cycle();
        cycle();
        check("b2b drained", int'(busy), 0);

        // Operand change mid-CALC must not affect the result.
        mcand  = 4'd3;
        mplier = 4'd5;
        init   = 1'b1;
        cycle();
        init = 1'b0;
        cycle();
        cycle();
        mcand  = 4'd9;
        mplier = 4'd9;
        seen = 0;
        for (int i = 3; i <= 20; i++) begin
            cycle();
            if (done) begin
                seen = i;
                break;
            end
        end
        check("opchg latency", seen, FullLat);
        check("opchg producto", int'(producto), 8'h0F);
        cycle();

        // Reset asserted at edge 3 of an operation.
        mcand  = 4'd13;
        mplier = 4'd11;
        init   = 1'b1;
        cycle();
        init = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst busy", int'(busy), 0);
        check("midrst producto", int'(producto), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (done) seen++;
        end
        check("midrst no_done", seen, 0);
        check("midrst producto_after", int'(producto), 0);
        run_op("after_rst", 4'd2, 4'd6, 8'h0C, FullLat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
